err_compute_ctrl: RTL and testbench
===================================

# err_compute_ctrl

Control sequencer for the line-follower error accumulator datapath. Each IR_vld frame it clears the datapath accumulator, then walks the eight IR operands with the right/left add/subtract pattern. It then pulses err_vld once the signed error is final. It sits between the IR sampling front end, which produces IR_vld, and the error datapath plus PID, which consume sel/sub/en_accum/clr_accum and err_vld.

## Interface
- Parameters: none; sequence length fixed at 8 by package constant NUM_TERMS.
- clk  input  1  50MHz system clock
- rst_n  input  1  asynchronous active-low reset
- IR_vld  input  1  single-cycle pulse: new IR_R0..3/IR_L0..3 readings are stable
- clr_accum  output  1  datapath accumulator synchronous clear
- en_accum  output  1  datapath accumulator enable
- sel  output  3  operand select: 0=R0, 1=L0, 2=R1, 3=L1, 4=R2, 5=L2, 6=R3, 7=L3
- sub  output  1  1 = subtract selected operand; always equals sel[0]
- err_vld  output  1  one-cycle pulse: datapath error holds the completed frame result
- busy  output  1  high in CLR and ACCUM

## Operation
- States: IDLE, CLR, ACCUM, DONE. The state type is an enum and the encoding is not fixed.
- IDLE:
  - All outputs 0.
  - IR_vld=1 -> CLR.
- CLR (1 cycle):
  - clr_accum=1, en_accum=0, sel=0.
  - Always -> ACCUM.
- ACCUM (8 cycles):
  - en_accum=1; sel = 3-bit counter cnt, starting at 0 and incrementing each cycle; sub=cnt[0].
  - Right readings are added and left readings are subtracted, so the result is error = ΣR_weighted − ΣL_weighted.
  - cnt==7 -> DONE, and cnt wraps to 0.
- DONE (1 cycle):
  - err_vld=1, en_accum=0, clr_accum=0.
  - If IR_vld=1 or pend=1 -> CLR; otherwise -> IDLE.
- clr_accum and en_accum are never high together.
- sel holds 0 outside ACCUM. sub holds 0 outside ACCUM.
- All outputs are Moore, decoded from the state/cnt registers. There is no combinational path from IR_vld to any output.
- Reset (any time, including mid-ACCUM):
  - State -> IDLE, cnt=0, pend=0.
  - All outputs 0 asynchronously.
  - The partial frame is abandoned, and no err_vld is produced for it.

## Timing
- IR_vld sampled high at edge k in IDLE:
  - cycle k+1: clr_accum=1.
  - cycles k+2..k+9: en_accum=1 with sel=0..7.
  - cycle k+10: err_vld=1.
  - cycle k+11: IDLE, or CLR if a request is pending.
- Latency from IR_vld to err_vld: 10 cycles. Frame period with back-to-back requests: 10 cycles.
- The datapath accumulates on the edge ending each ACCUM cycle. Error is therefore final at the start of the DONE cycle and stays stable until the next CLR.
- An IR_vld pulse in DONE is accepted directly: the next cycle is CLR, with no IDLE bubble.

## Configuration
- ERR_CTRL_PEND_EN defined:
  - A 1-bit pend register is set by IR_vld while in CLR or ACCUM.
  - pend is cleared on entry to CLR from DONE.
  - Multiple pulses while busy collapse into one pending frame.
- ERR_CTRL_PEND_EN undefined:
  - IR_vld in CLR or ACCUM is ignored.
  - pend is tied 0.
  - DONE -> CLR happens only on IR_vld in that cycle.

## Structure
- Shared package err_ctrl_pkg:
  - typedef enum logic [1:0] err_ctrl_state_t {IDLE, CLR, ACCUM, DONE}
  - localparam NUM_TERMS = 8
  - localparam SEL_W = 3
- One sub-module is natural: err_sel_cnt, a 3-bit counter.
  - Inputs: clk, rst_n, inc, clr.
  - Outputs: cnt and last (cnt==NUM_TERMS-1).
- The controller holds the state register, the pend register and the output decode.

## Test plan
- Single frame: IR_vld at cycle 5 -> clr_accum at 6; en_accum at 7..14 with sel 0,1,…,7 and sub 0,1,0,1,0,1,0,1; err_vld at 15 only.
- With the datapath attached, all R=12'h100 and all L=12'h080 -> error at err_vld = (0x100−0x80)·(1+2+4+8) = 16'h0780.
- Reset mid-frame: rst_n low at cycle 10 (ACCUM, sel=3) -> all outputs 0 immediately; no err_vld follows; a new IR_vld after release gives a normal 10-cycle frame.
- IR_vld in DONE (cycle 15) -> clr_accum at 16 and err_vld at 25; no idle cycle.
- IR_vld at cycles 9 and 11 during ACCUM:
  - With ERR_CTRL_PEND_EN: a second frame starts (clr_accum at 16) and exactly 2 err_vld pulses occur.
  - Without ERR_CTRL_PEND_EN: exactly 1 err_vld pulse and IDLE at 16.
- Invariant check over random IR_vld traffic:
  - clr_accum&en_accum never 1.
  - sub==sel[0] whenever en_accum=1.
  - err_vld is never asserted in two consecutive cycles.

Source files
------------

// File: rtl/err_ctrl_pkg.sv
// rtl/err_ctrl_pkg.sv - shared state type and sequence constants for the error sequencer
package err_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, CLR, ACCUM, DONE} err_ctrl_state_t;

  localparam int NUM_TERMS = 8;
  localparam int SEL_W     = 3;

endpackage

// File: rtl/err_sel_cnt.sv
// rtl/err_sel_cnt.sv - operand select counter walking the NUM_TERMS IR operands
module err_sel_cnt
  import err_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [SEL_W-1:0] cnt,
  output logic             last
);

  // Count operands while accumulating; clear holds it at 0 otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + SEL_W'(1);
    end
  end

  assign last = (cnt == SEL_W'(NUM_TERMS - 1));

endmodule

// File: rtl/err_compute_ctrl.sv
// rtl/err_compute_ctrl.sv - IR error accumulator sequencer; ERR_CTRL_PEND_EN queues one request while busy
module err_compute_ctrl
  import err_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       IR_vld,
  output logic       clr_accum,
  output logic       en_accum,
  output logic [2:0] sel,
  output logic       sub,
  output logic       err_vld,
  output logic       busy
);

  err_ctrl_state_t  state;
  err_ctrl_state_t  state_nxt;
  logic [SEL_W-1:0] cnt;
  logic             last;
  logic             pend;

  // The counter only runs in ACCUM, so it wraps 7->0 on the way to DONE
  // and is held at 0 in every other state.
  err_sel_cnt u_sel_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (state == ACCUM),
    .clr   (state != ACCUM),
    .cnt   (cnt),
    .last  (last)
  );

`ifdef ERR_CTRL_PEND_EN
  // Remember one request arriving mid-frame; DONE always consumes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 1'b0;
    end else if ((state == CLR || state == ACCUM) && IR_vld) begin
      pend <= 1'b1;
    end else if (state == DONE) begin
      pend <= 1'b0;
    end
  end
`else
  assign pend = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and Moore output decode from state and counter only.
  always_comb begin
    state_nxt = state;
    clr_accum = 1'b0;
    en_accum  = 1'b0;
    sel       = '0;
    err_vld   = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (IR_vld) state_nxt = CLR;
      end
      CLR: begin
        clr_accum = 1'b1;
        busy      = 1'b1;
        state_nxt = ACCUM;
      end
      ACCUM: begin
        en_accum = 1'b1;
        busy     = 1'b1;
        sel      = cnt;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        err_vld   = 1'b1;
        state_nxt = (IR_vld || pend) ? CLR : IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Odd selects are the left readings, which are subtracted.
  assign sub = sel[0];

endmodule

// File: tb/tb_err_compute_ctrl.sv
// tb/tb_err_compute_ctrl.sv - scoreboard bench for err_compute_ctrl (ERR_CTRL_PEND_EN aware)
module tb_err_compute_ctrl;

`ifdef ERR_CTRL_PEND_EN
  localparam bit PEND = 1'b1;
`else
  localparam bit PEND = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       IR_vld = 1'b0;
  logic       clr_accum;
  logic       en_accum;
  logic [2:0] sel;
  logic       sub;
  logic       err_vld;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;

  logic [7:0]  exp_q[$];
  logic [15:0] acc;
  logic [15:0] opnd;

  int m_phase = 0;
  bit m_pend = 1'b0;

  err_compute_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .IR_vld    (IR_vld),
    .clr_accum (clr_accum),
    .en_accum  (en_accum),
    .sel       (sel),
    .sub       (sub),
    .err_vld   (err_vld),
    .busy      (busy)
  );

  always #10 clk = ~clk;

  // Datapath stand-in: all R readings 0x100, all L readings 0x080, weight 2^(sel/2).
  assign opnd = (sel[0] ? 16'h0080 : 16'h0100) << sel[2:1];
  always @(posedge clk) begin
    if (clr_accum) acc <= 16'h0000;
    else if (en_accum) acc <= sub ? acc - opnd : acc + opnd;
  end

  // Frame model: phase 0 idle, 1 clear, 2..9 accumulate, 10 result.
  function automatic logic [7:0] model_out();
    logic [2:0] s;
    logic c, e, d, b;
    c = (m_phase == 1);
    e = (m_phase >= 2) && (m_phase <= 9);
    s = e ? 3'(m_phase - 2) : 3'd0;
    d = (m_phase == 10);
    b = (m_phase >= 1) && (m_phase <= 9);
    return {c, e, s, s[0], d, b};
  endfunction

  task automatic model_step(input logic vld);
    if (m_phase == 0) begin
      if (vld) m_phase = 1;
    end else if (m_phase < 10) begin
      if (vld && PEND) m_pend = 1'b1;
      m_phase = m_phase + 1;
    end else begin
      if (vld || m_pend) begin
        m_phase = 1;
        m_pend = 1'b0;
      end else begin
        m_phase = 0;
      end
    end
  endtask

  // One clock: drive IR_vld, queue the expected outputs for the next cycle.
  task automatic cycle(input logic vld);
    IR_vld = vld;
    model_step(vld);
    exp_q.push_back(model_out());
    @(posedge clk);
    @(negedge clk);
    #1;
    IR_vld = 1'b0;
  endtask

  // Monitor: pop expectations and check invariants away from the active edge.
  initial begin
    logic [7:0] e_v;
    logic [7:0] a_v;
    logic       prev_err;
    prev_err = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && exp_q.size() > 0) begin
        e_v = exp_q.pop_front();
        a_v = {clr_accum, en_accum, sel, sub, err_vld, busy};
        checks++;
        if (a_v !== e_v) begin
          errors++;
          $display("FAIL seq_outputs t=%0t got {clr,en,sel,sub,err,busy}=%b expected %b", $time, a_v, e_v);
        end
        checks++;
        if (clr_accum && en_accum) begin
          errors++;
          $display("FAIL clr_en_overlap t=%0t got 1 expected 0", $time);
        end
        if (en_accum) begin
          checks++;
          if (sub !== sel[0]) begin
            errors++;
            $display("FAIL sub_eq_sel0 t=%0t got sub=%b expected %b", $time, sub, sel[0]);
          end
        end
        checks++;
        if (err_vld && prev_err) begin
          errors++;
          $display("FAIL err_vld_double t=%0t got two consecutive pulses expected one", $time);
        end
        if (err_vld) begin
          err_seen++;
          checks++;
          if (acc !== 16'h0780) begin
            errors++;
            $display("FAIL frame_error t=%0t got %h expected 0780", $time, acc);
          end
        end
      end
      prev_err = err_vld;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    IR_vld = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({clr_accum, en_accum, sel, sub, err_vld, busy} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got %b expected 00000000", {clr_accum, en_accum, sel, sub, err_vld, busy});
    end
    rst_n = 1'b1;
    repeat (2) cycle(1'b0);
  endtask

  task automatic test_single_frame();
    err_seen = 0;
    cycle(1'b1);
    checks++;
    if (clr_accum !== 1'b1) begin
      errors++;
      $display("FAIL single_clr_latency got %b expected 1", clr_accum);
    end
    repeat (14) cycle(1'b0);
    checks++;
    if (err_seen !== 1) begin
      errors++;
      $display("FAIL single_err_count got %0d expected 1", err_seen);
    end
  endtask

  task automatic test_reset_mid_frame();
    cycle(1'b1);
    repeat (4) cycle(1'b0);
    checks++;
    if (sel !== 3'd3 || en_accum !== 1'b1) begin
      errors++;
      $display("FAIL midframe_pre sel=%0d en=%b expected sel=3 en=1", sel, en_accum);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({clr_accum, en_accum, sel, sub, err_vld, busy} !== 8'h00) begin
      errors++;
      $display("FAIL midframe_async_reset got %b expected 00000000", {clr_accum, en_accum, sel, sub, err_vld, busy});
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    m_phase = 0;
    m_pend = 1'b0;
    exp_q.delete();
    err_seen = 0;
    repeat (12) cycle(1'b0);
    checks++;
    if (err_seen !== 0) begin
      errors++;
      $display("FAIL midframe_no_err got %0d expected 0", err_seen);
    end
    cycle(1'b1);
    repeat (11) cycle(1'b0);
    checks++;
    if (err_seen !== 1) begin
      errors++;
      $display("FAIL midframe_new_frame got %0d expected 1", err_seen);
    end
  endtask

  task automatic test_back_to_back();
    err_seen = 0;
    cycle(1'b1);
    repeat (9) cycle(1'b0);
    checks++;
    if (err_vld !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done got %b expected 1", err_vld);
    end
    cycle(1'b1);
    checks++;
    if (clr_accum !== 1'b1) begin
      errors++;
      $display("FAIL b2b_no_bubble got clr=%b expected 1", clr_accum);
    end
    repeat (12) cycle(1'b0);
    checks++;
    if (err_seen !== 2) begin
      errors++;
      $display("FAIL b2b_err_count got %0d expected 2", err_seen);
    end
  endtask

  task automatic test_busy_pulses();
    err_seen = 0;
    cycle(1'b1);
    repeat (2) cycle(1'b0);
    cycle(1'b1);
    cycle(1'b0);
    cycle(1'b1);
    repeat (5) cycle(1'b0);
    checks++;
    if (clr_accum !== PEND || busy !== PEND) begin
      errors++;
      $display("FAIL busy_follow_on got clr=%b busy=%b expected %b", clr_accum, busy, PEND);
    end
    repeat (20) cycle(1'b0);
    checks++;
    if (err_seen !== (PEND ? 2 : 1)) begin
      errors++;
      $display("FAIL busy_err_count got %0d expected %0d", err_seen, (PEND ? 2 : 1));
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) == 0);
    end
    repeat (15) cycle(1'b0);
    checks++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL random_drain got busy=%b pending=%0d expected 0 0", busy, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_reset_mid_frame();
    test_back_to_back();
    test_busy_pulses();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
